mpu_int_mul_ctrl: RTL and testbench

MPU_INT_MUL_CTRL -- requirements
Module: mpu_int_mul_ctrl

---
 rtl/mpu_pkg.sv | 21 ++
 rtl/mpu_int_mul_ctrl_if.sv | 36 +++
 rtl/mpu_scalar_mul_stage.sv | 37 +++
 rtl/mpu_int_mul_ctrl.sv | 117 +++++++++++
 tb/tb_mpu_int_mul_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpu_pkg.sv
// Shared definitions for the matrix-scalar multiply unit: default sizes,
// controller state encoding and the address-width helper.
package mpu_pkg;

   localparam int N_DEF      = 5;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Width needed to address every element of an n x n matrix (at least 1 bit).
   function automatic int addr_w(input int n);
      if (n * n > 1) return $clog2(n * n);
      else           return 1;
   endfunction

endpackage

// File: rtl/mpu_int_mul_ctrl_if.sv
// Handshake, memory read port and memory write port of the multiply controller.
// The master side drives commands and read data; the slave side is the controller.
interface mpu_int_mul_ctrl_if
   import mpu_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   localparam int ADDR_W = addr_w(N);

   logic              start;
   logic [DATA_W-1:0] factor;
   logic              abort;
   logic              stall;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;
   logic              ovf;

   modport master (
      output start, factor, abort, stall, rd_data,
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, ovf
   );

   modport slave (
      input  start, factor, abort, stall, rd_data,
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, ovf
   );

endinterface

// File: rtl/mpu_scalar_mul_stage.sv
// Registered element x factor stage: produces the value to write and a flag
// telling whether the full-width product spilled above DATA_W bits.
module mpu_scalar_mul_stage
   import mpu_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int SATURATE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] elem,
   input  logic [DATA_W-1:0] factor,
   output logic [DATA_W-1:0] prod_data,
   output logic              prod_ovf
);

   logic [2*DATA_W-1:0] prod;
   logic                hi_nz;
   logic [DATA_W-1:0]   result;

   assign prod   = {{DATA_W{1'b0}}, elem} * {{DATA_W{1'b0}}, factor};
   assign hi_nz  = |prod[2*DATA_W-1:DATA_W];
   assign result = ((SATURATE != 0) && hi_nz) ? {DATA_W{1'b1}} : prod[DATA_W-1:0];

   // Capture the product only when a valid element is moving down the pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_data <= '0;
         prod_ovf  <= 1'b0;
      end else if (en) begin
         prod_data <= result;
         prod_ovf  <= hi_nz;
      end
   end

endmodule

// File: rtl/mpu_int_mul_ctrl.sv
// Matrix-scalar multiply controller: walks every source element in address
// order, multiplies it by a latched factor and writes the result two cycles
// after the read. Stall freezes everything; abort drops the pass.
module mpu_int_mul_ctrl
   import mpu_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int SATURATE = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   mpu_int_mul_ctrl_if.slave  bus
);

   localparam int              ADDR_W    = addr_w(N);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N * N - 1);

   state_t            state;
   logic [DATA_W-1:0] factor_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W-1:0] rd_pipe_addr;
   logic [ADDR_W-1:0] wr_addr_q;
   logic              rd_pipe_vld;
   logic              wr_pipe_vld;
   logic              busy_q;
   logic              done_q;
   logic              ovf_q;
   logic              rd_fire;
   logic              wr_fire;
   logic              mul_en;
   logic [DATA_W-1:0] mul_data;
   logic              mul_ovf;

   // Stall has to silence the strobes in the very cycle it is raised.
   assign rd_fire = (state == RUN) && !bus.stall;
   assign wr_fire = wr_pipe_vld && !bus.stall;
   assign mul_en  = rd_pipe_vld && !bus.stall;

   mpu_scalar_mul_stage #(
      .DATA_W   (DATA_W),
      .SATURATE (SATURATE)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (mul_en),
      .elem      (bus.rd_data),
      .factor    (factor_q),
      .prod_data (mul_data),
      .prod_ovf  (mul_ovf)
   );

   // Pass sequencing, read address counter, pipeline valids and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         factor_q     <= '0;
         rd_addr_q    <= '0;
         rd_pipe_addr <= '0;
         wr_addr_q    <= '0;
         rd_pipe_vld  <= 1'b0;
         wr_pipe_vld  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else if (bus.abort && (state != IDLE)) begin
         state       <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_pipe_vld <= 1'b0;
         wr_pipe_vld <= 1'b0;
      end else if (!bus.stall) begin
         rd_pipe_vld  <= rd_fire;
         rd_pipe_addr <= rd_addr_q;
         wr_pipe_vld  <= rd_pipe_vld;
         if (rd_pipe_vld) wr_addr_q <= rd_pipe_addr;
         if (wr_pipe_vld && mul_ovf) ovf_q <= 1'b1;
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  factor_q  <= bus.factor;
                  ovf_q     <= 1'b0;
                  rd_addr_q <= '0;
                  busy_q    <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (rd_addr_q == LAST_ADDR) state <= DRAIN;
               else                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
            DRAIN: begin
               if (wr_pipe_vld && (wr_addr_q == LAST_ADDR)) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rd_en   = rd_fire;
   assign bus.rd_addr = rd_addr_q;
   assign bus.wr_en   = wr_fire;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = mul_data;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_mpu_int_mul_ctrl.sv
// Bench for the matrix-scalar multiply controller. Two copies run side by side
// on the same stimulus, one wrapping products and one saturating them. A
// per-pass schedule of expected reads, writes and done is derived from the
// list of non-stalled cycles and the element products.
module tb_mpu_int_mul_ctrl;
   import mpu_pkg::*;

   localparam int N    = 5;
   localparam int DW   = 8;
   localparam int NN   = N * N;
   localparam int AW   = addr_w(N);
   localparam int MAXC = 160;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          stall = 1'b0;
   logic [DW-1:0] factor = '0;
   logic [DW-1:0] rd_data0 = '0;
   logic [DW-1:0] rd_data1 = '0;

   int vectors = 0;
   int miscompares = 0;

   int mem[NN];
   int cur_factor;
   bit stall_pat[MAXC];

   int rcyc[NN];
   int wcyc[NN];
   int d0[NN];
   int d1[NN];
   int exp_done;
   bit exp_ovf;

   mpu_int_mul_ctrl_if #(.N(N), .DATA_W(DW)) bus0 ();
   mpu_int_mul_ctrl_if #(.N(N), .DATA_W(DW)) bus1 ();

   assign bus0.start   = start;
   assign bus0.factor  = factor;
   assign bus0.abort   = abort;
   assign bus0.stall   = stall;
   assign bus0.rd_data = rd_data0;
   assign bus1.start   = start;
   assign bus1.factor  = factor;
   assign bus1.abort   = abort;
   assign bus1.stall   = stall;
   assign bus1.rd_data = rd_data1;

   mpu_int_mul_ctrl #(.N(N), .DATA_W(DW), .SATURATE(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   mpu_int_mul_ctrl #(.N(N), .DATA_W(DW), .SATURATE(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   always #5 clk = ~clk;

   // Source memories: data appears the cycle after the strobe and is held.
   always @(posedge clk) begin
      if (bus0.rd_en) rd_data0 <= DW'(mem[bus0.rd_addr]);
      if (bus1.rd_en) rd_data1 <= DW'(mem[bus1.rd_addr]);
   end

   task automatic clear_stalls();
      for (int i = 0; i < MAXC; i++) stall_pat[i] = 1'b0;
   endtask

   // Element k is read in the k-th unstalled cycle after start, written two
   // unstalled cycles later, and done follows the cycle of the last write.
   task automatic build_model();
      int c[$];
      int p;
      c = {};
      for (int cy = 1; cy < MAXC && c.size() < NN + 2; cy++)
         if (!stall_pat[cy]) c.push_back(cy);
      exp_ovf = 1'b0;
      for (int k = 0; k < NN; k++) begin
         rcyc[k] = c[k];
         wcyc[k] = c[k + 2];
         p       = mem[k] * cur_factor;
         d0[k]   = p % (1 << DW);
         d1[k]   = (p > (1 << DW) - 1) ? (1 << DW) - 1 : p;
         if (p > (1 << DW) - 1) exp_ovf = 1'b1;
      end
      exp_done = c[NN + 1] + 1;
   endtask

   task automatic check_all_zero(input string tag);
      logic [4+3*AW+2*DW:0] obs0, obs1;
      obs0 = {bus0.rd_en, bus0.wr_en, bus0.busy, bus0.done, bus0.ovf, bus0.rd_addr, bus0.wr_addr, bus0.wr_data};
      obs1 = {bus1.rd_en, bus1.wr_en, bus1.busy, bus1.done, bus1.ovf, bus1.rd_addr, bus1.wr_addr, bus1.wr_data};
      vectors += 2;
      if (obs0 !== '0) begin
         miscompares++;
         $display("FAIL %s outputs0 got %h want 0", tag, obs0);
      end
      if (obs1 !== '0) begin
         miscompares++;
         $display("FAIL %s outputs1 got %h want 0", tag, obs1);
      end
   endtask

   // One full pass from start; negative cycle arguments disable that event.
   task automatic run_pass(input string tag, input int abort_cyc, input int restart_cyc, input int rst_cyc);
      int ri, wi, last;
      bit exp_rd, exp_wr, exp_busy, exp_dn;
      logic [3:0] obs0, obs1, expv;
      ri = 0;
      wi = 0;
      build_model();
      if (abort_cyc >= 0)    last = abort_cyc + 4;
      else if (rst_cyc >= 0) last = rst_cyc;
      else                   last = exp_done + 2;
      for (int k = 0; k <= last; k++) begin
         @(posedge clk);
         #1;
         start  = (k == 0) || (k == restart_cyc);
         factor = (k == 0) ? DW'(cur_factor) : DW'($urandom);
         abort  = (k == abort_cyc);
         stall  = stall_pat[k];
         if (k == rst_cyc) begin
            rst_n = 1'b0;
            start = 1'b0;
            stall = 1'b0;
            abort = 1'b0;
            #1;
            check_all_zero({tag, " in_reset"});
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         @(negedge clk);
         exp_rd   = (ri < NN) && (rcyc[ri] == k) && (abort_cyc < 0 || k <= abort_cyc);
         exp_wr   = (wi < NN) && (wcyc[wi] == k) && (abort_cyc < 0 || k <= abort_cyc);
         exp_busy = (abort_cyc >= 0) ? (k >= 1 && k <= abort_cyc) : (k >= 1 && k <= exp_done);
         exp_dn   = (abort_cyc < 0) && (k == exp_done);
         expv = {exp_rd, exp_wr, exp_busy, exp_dn};
         obs0 = {bus0.rd_en, bus0.wr_en, bus0.busy, bus0.done};
         obs1 = {bus1.rd_en, bus1.wr_en, bus1.busy, bus1.done};
         vectors += 2;
         if (obs0 !== expv) begin
            miscompares++;
            $display("FAIL %s ctrl0 cyc %0d rd/wr/busy/done got %b want %b", tag, k, obs0, expv);
         end
         if (obs1 !== expv) begin
            miscompares++;
            $display("FAIL %s ctrl1 cyc %0d rd/wr/busy/done got %b want %b", tag, k, obs1, expv);
         end
         if (exp_rd) begin
            vectors++;
            if (bus0.rd_addr !== AW'(ri)) begin
               miscompares++;
               $display("FAIL %s rd_addr cyc %0d got %0d want %0d", tag, k, bus0.rd_addr, ri);
            end
            ri++;
         end
         if (exp_wr) begin
            vectors += 3;
            if (bus0.wr_addr !== AW'(wi) || bus1.wr_addr !== AW'(wi)) begin
               miscompares++;
               $display("FAIL %s wr_addr cyc %0d got %0d/%0d want %0d", tag, k, bus0.wr_addr, bus1.wr_addr, wi);
            end
            if (bus0.wr_data !== DW'(d0[wi])) begin
               miscompares++;
               $display("FAIL %s wr_data_wrap addr %0d got %0d want %0d", tag, wi, bus0.wr_data, d0[wi]);
            end
            if (bus1.wr_data !== DW'(d1[wi])) begin
               miscompares++;
               $display("FAIL %s wr_data_sat addr %0d got %0d want %0d", tag, wi, bus1.wr_data, d1[wi]);
            end
            wi++;
         end
      end
      start = 1'b0;
      abort = 1'b0;
      stall = 1'b0;
      if (abort_cyc < 0 || !exp_ovf) begin
         vectors += 2;
         if (bus0.ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL %s ovf0 got %b want %b", tag, bus0.ovf, exp_ovf);
         end
         if (bus1.ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL %s ovf1 got %b want %b", tag, bus1.ovf, exp_ovf);
         end
      end
   endtask

   task automatic load_ramp();
      for (int k = 0; k < NN; k++) mem[k] = k;
   endtask

   task automatic load_random();
      for (int k = 0; k < NN; k++) mem[k] = int'($urandom_range(0, (1 << DW) - 1));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("after_reset");
   endtask

   task automatic test_ramp();
      clear_stalls();
      load_ramp();
      cur_factor = 3;
      run_pass("ramp", -1, -1, -1);
   endtask

   task automatic test_overflow();
      clear_stalls();
      for (int k = 0; k < NN; k++) mem[k] = 200;
      cur_factor = 2;
      run_pass("overflow", -1, -1, -1);
   endtask

   task automatic test_stall();
      clear_stalls();
      load_ramp();
      cur_factor = 7;
      for (int c = 5; c <= 7; c++) stall_pat[c] = 1'b1;
      run_pass("stall", -1, -1, -1);
   endtask

   task automatic test_abort();
      clear_stalls();
      load_ramp();
      cur_factor = 3;
      run_pass("abort", 10, -1, -1);
      run_pass("after_abort", -1, -1, -1);
      stall_pat[9]  = 1'b1;
      stall_pat[10] = 1'b1;
      run_pass("abort_stall", 10, -1, -1);
      clear_stalls();
      run_pass("after_abort_stall", -1, -1, -1);
   endtask

   task automatic test_restart_ignored();
      clear_stalls();
      load_random();
      cur_factor = int'($urandom_range(0, (1 << DW) - 1));
      run_pass("restart", -1, 12, -1);
   endtask

   task automatic test_reset_mid_pass();
      clear_stalls();
      load_random();
      cur_factor = 5;
      run_pass("mid_reset", -1, -1, 15);
      run_pass("after_mid_reset", -1, -1, -1);
   endtask

   // Start must be refused when it coincides with stall or abort in IDLE.
   task automatic test_start_blocked();
      for (int m = 0; m < 2; m++) begin
         @(posedge clk);
         #1;
         start  = 1'b1;
         factor = DW'($urandom);
         stall  = (m == 0);
         abort  = (m == 1);
         @(posedge clk);
         #1;
         start = 1'b0;
         stall = 1'b0;
         abort = 1'b0;
         @(negedge clk);
         vectors++;
         if ({bus0.busy, bus0.rd_en, bus1.busy, bus1.rd_en} !== 4'b0000) begin
            miscompares++;
            $display("FAIL start_blocked mode %0d busy/rd got %b%b%b%b want 0000", m,
                     bus0.busy, bus0.rd_en, bus1.busy, bus1.rd_en);
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 4; t++) begin
         clear_stalls();
         load_random();
         cur_factor = int'($urandom_range(0, (1 << DW) - 1));
         for (int c = 1; c <= 20; c++) stall_pat[c] = ($urandom_range(0, 3) == 0);
         run_pass("random", -1, -1, -1);
      end
   endtask

   task automatic test_back_to_back();
      clear_stalls();
      load_random();
      cur_factor = 1;
      run_pass("b2b_a", -1, -1, -1);
      cur_factor = 0;
      run_pass("b2b_b", -1, -1, -1);
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_overflow();
      test_stall();
      test_abort();
      test_restart_ignored();
      test_reset_mid_pass();
      test_start_blocked();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
